// File: rtl/keccak_arbiter.sv
// rtl/keccak_arbiter.sv - round-robin arbiter sharing one keccak core among NUM_REQ hash clients.
// Optional KECCAK_ARB_PRIO_EN: requester 0 gets strict priority over the round-robin pool.
module keccak_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_REQ-1:0]      i_req,
  input  logic [2*NUM_REQ-1:0]    i_req_mode,
  input  logic [11*NUM_REQ-1:0]   i_req_ibytes_len,
  input  logic [10*NUM_REQ-1:0]   i_req_obytes_len,
  input  logic [64*NUM_REQ-1:0]   i_req_ibytes,
  input  logic [NUM_REQ-1:0]      i_req_ibytes_valid,
  output logic [NUM_REQ-1:0]      o_req_ibytes_ready,
  output logic [NUM_REQ-1:0]      o_gnt,
  output logic [IDX_W-1:0]        o_gnt_idx,
  output logic [63:0]             o_req_obytes,
  output logic [NUM_REQ-1:0]      o_req_obytes_valid,
  output logic [NUM_REQ-1:0]      o_req_done,
  output logic [1:0]              o_kc_mode,
  output logic [10:0]             o_kc_ibytes_len,
  output logic [9:0]              o_kc_obytes_len,
  output logic [63:0]             o_kc_ibytes,
  output logic                    o_kc_ibytes_valid,
  input  logic                    i_kc_ibytes_ready,
  input  logic [63:0]             i_kc_obytes,
  input  logic                    i_kc_obytes_valid,
  input  logic                    i_kc_obytes_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [1:0]         kc_mode_q, kc_mode_d;
  logic [10:0]        kc_ibytes_len_q, kc_ibytes_len_d;
  logic [9:0]         kc_obytes_len_q, kc_obytes_len_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W:0]     cand;
  logic [1:0]         win_mode;
  logic [10:0]        win_ibytes_len;
  logic [9:0]         win_obytes_len;

  // Cyclic search from rr_ptr; the first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!win_found && i_req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
`ifdef KECCAK_ARB_PRIO_EN
    if (i_req[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
  end

  always_comb begin
    win_mode       = '0;
    win_ibytes_len = '0;
    win_obytes_len = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_mode       = i_req_mode[2*i +: 2];
        win_ibytes_len = i_req_ibytes_len[11*i +: 11];
        win_obytes_len = i_req_obytes_len[10*i +: 10];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    gnt_idx_d       = gnt_idx_q;
    rr_ptr_d        = rr_ptr_q;
    kc_mode_d       = kc_mode_q;
    kc_ibytes_len_d = kc_ibytes_len_q;
    kc_obytes_len_d = kc_obytes_len_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d           = NUM_REQ'(1) << win_idx;
          gnt_idx_d       = win_idx;
          kc_mode_d       = win_mode;
          kc_ibytes_len_d = win_ibytes_len;
          kc_obytes_len_d = win_obytes_len;
          state_d         = S_GRANT;
        end
      end
      S_GRANT: state_d = S_BUSY;
      S_BUSY: begin
        if (i_kc_obytes_done) begin
`ifdef KECCAK_ARB_PRIO_EN
          if (gnt_idx_q != '0) begin
            rr_ptr_d = (gnt_idx_q == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx_q + 1'b1;
          end
`else
          rr_ptr_d = (gnt_idx_q == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx_q + 1'b1;
`endif
          gnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= S_IDLE;
      gnt_q           <= '0;
      gnt_idx_q       <= '0;
      rr_ptr_q        <= '0;
      kc_mode_q       <= '0;
      kc_ibytes_len_q <= '0;
      kc_obytes_len_q <= '0;
    end else begin
      state_q         <= state_d;
      gnt_q           <= gnt_d;
      gnt_idx_q       <= gnt_idx_d;
      rr_ptr_q        <= rr_ptr_d;
      kc_mode_q       <= kc_mode_d;
      kc_ibytes_len_q <= kc_ibytes_len_d;
      kc_obytes_len_q <= kc_obytes_len_d;
    end
  end

  // Streams connect only while busy, so stray core valids never leak out.
  always_comb begin
    o_kc_ibytes        = '0;
    o_kc_ibytes_valid  = 1'b0;
    o_req_ibytes_ready = '0;
    o_req_obytes       = '0;
    o_req_obytes_valid = '0;
    o_req_done         = '0;
    if (state_q == S_BUSY) begin
      o_req_obytes = i_kc_obytes;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt_idx_q == IDX_W'(i)) begin
          o_kc_ibytes           = i_req_ibytes[64*i +: 64];
          o_kc_ibytes_valid     = i_req_ibytes_valid[i];
          o_req_ibytes_ready[i] = i_kc_ibytes_ready;
          o_req_obytes_valid[i] = i_kc_obytes_valid;
          o_req_done[i]         = i_kc_obytes_done;
        end
      end
    end
  end

  assign o_gnt           = gnt_q;
  assign o_gnt_idx       = gnt_idx_q;
  assign o_kc_mode       = kc_mode_q;
  assign o_kc_ibytes_len = kc_ibytes_len_q;
  assign o_kc_obytes_len = kc_obytes_len_q;

endmodule
